npu_frame_loader: RTL
=====================

Name: npu_frame_loader

Overview:
Upstream feeder for top_network. Accepts a byte stream over a valid/ready handshake and unpacks it into the image and weight buffers that drive the network's array inputs. Once a frame is loaded, it pulses the network start, waits for done, and returns the 24-bit result over a valid/ready result port. Weights stay resident, so later frames can carry the image only.

Parameters:
IMG_N, 240, image bytes (16x15)
C1W_N, 90, conv1 weight bytes
C2W_N, 90, conv2 weight bytes
FC1W_N, 1320, fc1 weight bytes
FC2W_N, 10, fc2 weight bytes

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cmd_valid  in  1  frame-start command (sampled in S_IDLE only)
cmd_wload  in  1  1 = frame carries weights plus image; 0 = image only
s_valid  in  1  stream byte valid
s_data  in  8  stream byte (signed)
s_ready  out  1  loader accepts byte
img_buf  out  8*IMG_N  image buffer; byte k at bits [8k+7:8k]
c1w_buf  out  8*C1W_N  conv1 weights, same packing
c2w_buf  out  8*C2W_N  conv2 weights
fc1w_buf  out  8*FC1W_N  fc1 weights
fc2w_buf  out  8*FC2W_N  fc2 weights
net_start  out  1  one-cycle start pulse to network
net_done  in  1  network done
net_out  in  24  network result
res_valid  out  1  result valid
res_data  out  24  result
res_ready  in  1  result consumer ready
busy  out  1  high when not in S_IDLE
weights_loaded  out  1  weight buffers hold a complete set
err  out  1  frame error (see Optional Feature)

Behaviour:
- Reset: state S_IDLE; all buffers zero; all outputs 0 (s_ready, net_start, res_valid, res_data, busy, weights_loaded, err). Reset mid-frame aborts the frame and clears weights_loaded.
- States: S_IDLE, S_LOAD, S_START, S_WAIT, S_RESULT.
- S_IDLE:
  - On cmd_valid, latch mode: full = cmd_wload | !weights_loaded.
  - Payload length is 1750 when full, else IMG_N. A full frame clears weights_loaded immediately.
  - Byte counter is cleared; go to S_LOAD.
- S_LOAD:
  - s_ready = 1. A byte transfers on s_valid & s_ready; the counter increments once per transfer.
  - Stream order for a full frame: image, conv1, conv2, fc1, fc2 weights. Region is decoded from the counter.
  - An image-only frame writes only img_buf.
  - On the last payload transfer, go to S_START next cycle. A full frame sets weights_loaded at the same time.
- S_START: net_start = 1 for exactly one cycle; go to S_WAIT.
- S_WAIT: on net_done, register net_out into res_data, set res_valid, go to S_RESULT.
- S_RESULT:
  - res_valid holds and res_data is stable until res_ready.
  - On the transfer, res_valid drops next cycle; go to S_IDLE.
  - res_ready asserted the same cycle res_valid rises completes a zero-wait transfer.
- s_ready = 0 outside S_LOAD. cmd_valid outside S_IDLE is ignored.
- Stall: s_valid low in S_LOAD holds the counter; there is no timeout.
- Latency: net_start is asserted 1 cycle after the last byte is accepted. res_valid rises 1 cycle after net_done.
- Buffers are written only in S_LOAD and are otherwise stable, including while the network runs.

Optional Feature:
NPU_LOADER_CHECKSUM_EN
- Defined:
  - One checksum byte follows each payload and is accepted in S_LOAD.
  - Pass condition: checksum equals the 8-bit modulo-256 sum of the payload bytes.
  - Mismatch: err = 1, no net_start, return to S_IDLE. A full frame leaves weights_loaded = 0.
  - err clears on the next accepted cmd_valid.
- Undefined: no checksum byte; err tied 0.

Test Plan:
1. Reset, cmd_valid with cmd_wload=1, then stream 1750 bytes where byte k = k mod 256 -> img_buf byte 0 = 0x00, c1w_buf byte 0 = 0xF0 (k=240), fc2w_buf byte 9 = 0xD5 (k=1749); weights_loaded = 1; net_start pulses 1 cycle, 1 cycle after the last byte.
2. After test 1, drive net_done with net_out = 24'hFFFF85 -> res_valid = 1, res_data = 24'hFFFF85. Hold res_ready=0 for 5 cycles -> output stable. Then res_ready=1 -> res_valid drops next cycle and busy = 0.
3. Image-only frame (cmd_wload=0) of 240 bytes all 0x7F -> img_buf all 0x7F; weight buffers unchanged; net_start after byte 240.
4. Image-only command issued immediately after reset -> treated as full; s_ready stays high for 1750 transfers.
5. Assert rst midway, after 500 bytes -> all outputs 0, weights_loaded = 0, s_ready = 0; s_valid during S_IDLE is not accepted.
6. With NPU_LOADER_CHECKSUM_EN defined, send an image-only frame with a wrong checksum -> err = 1, no net_start, return to S_IDLE. Resend with the correct checksum -> err = 0 and the run proceeds.

Source files
------------

// File: rtl/npu_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : npu_frame_loader
// Description : Unpacks a byte stream into image/weight buffers for top_network,
//               starts the network and returns its 24-bit result.
//               Optional checksum byte per frame: NPU_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module npu_frame_loader #(
  parameter int IMG_N  = 240,
  parameter int C1W_N  = 90,
  parameter int C2W_N  = 90,
  parameter int FC1W_N = 1320,
  parameter int FC2W_N = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  input  logic                  cmd_wload,
  input  logic                  s_valid,
  input  logic [7:0]            s_data,
  output logic                  s_ready,
  output logic [8*IMG_N-1:0]    img_buf,
  output logic [8*C1W_N-1:0]    c1w_buf,
  output logic [8*C2W_N-1:0]    c2w_buf,
  output logic [8*FC1W_N-1:0]   fc1w_buf,
  output logic [8*FC2W_N-1:0]   fc2w_buf,
  output logic                  net_start,
  input  logic                  net_done,
  input  logic [23:0]           net_out,
  output logic                  res_valid,
  output logic [23:0]           res_data,
  input  logic                  res_ready,
  output logic                  busy,
  output logic                  weights_loaded,
  output logic                  err
);

  localparam int FULL_N = IMG_N + C1W_N + C2W_N + FC1W_N + FC2W_N;
  localparam int CNT_W  = $clog2(FULL_N + 1);
  localparam logic [CNT_W-1:0] C_FULL_LEN = CNT_W'(FULL_N);
  localparam logic [CNT_W-1:0] C_IMG_LEN  = CNT_W'(IMG_N);
  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                full_q;
  logic                s_ready_q;
  logic                net_start_q;
  logic                res_valid_q;
  logic [23:0]         res_data_q;
  logic                busy_q;
  logic                wl_q;
  logic [8*FULL_N-1:0] pay_q;
`ifdef NPU_LOADER_CHECKSUM_EN
  logic [7:0]          sum_q;
  logic                err_q;
`endif

  logic [CNT_W-1:0] w_len;
  logic             w_pay_we;

  assign w_len    = full_q ? C_FULL_LEN : C_IMG_LEN;
  // Stream order equals buffer order, so the counter is the flat byte address.
  assign w_pay_we = (state_q == S_LOAD) && s_valid && s_ready_q && (cnt_q != w_len);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      full_q      <= 1'b0;
      s_ready_q   <= 1'b0;
      net_start_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      busy_q      <= 1'b0;
      wl_q        <= 1'b0;
`ifdef NPU_LOADER_CHECKSUM_EN
      sum_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            full_q    <= cmd_wload | ~wl_q;
            if (cmd_wload | ~wl_q) wl_q <= 1'b0;
            cnt_q     <= '0;
            s_ready_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_LOAD;
`ifdef NPU_LOADER_CHECKSUM_EN
            sum_q     <= '0;
            err_q     <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          if (s_valid && s_ready_q) begin
            if (cnt_q != w_len) begin
              cnt_q <= cnt_q + C_ONE;
`ifdef NPU_LOADER_CHECKSUM_EN
              sum_q <= sum_q + s_data;
`else
              if (cnt_q == w_len - C_ONE) begin
                s_ready_q   <= 1'b0;
                net_start_q <= 1'b1;
                if (full_q) wl_q <= 1'b1;
                state_q     <= S_START;
              end
`endif
            end
`ifdef NPU_LOADER_CHECKSUM_EN
            else if (s_data == sum_q) begin
              s_ready_q   <= 1'b0;
              net_start_q <= 1'b1;
              if (full_q) wl_q <= 1'b1;
              state_q     <= S_START;
            end else begin
              s_ready_q <= 1'b0;
              busy_q    <= 1'b0;
              err_q     <= 1'b1;
              state_q   <= S_IDLE;
            end
`endif
          end
        end
        S_START: begin
          net_start_q <= 1'b0;
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          if (net_done) begin
            res_data_q  <= net_out;
            res_valid_q <= 1'b1;
            state_q     <= S_RESULT;
          end
        end
        S_RESULT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pay_q <= '0;
    end else begin
      for (int k = 0; k < FULL_N; k++) begin
        if (w_pay_we && (cnt_q == CNT_W'(k))) pay_q[8*k +: 8] <= s_data;
      end
    end
  end

  assign img_buf  = pay_q[8*IMG_N-1 : 0];
  assign c1w_buf  = pay_q[8*(IMG_N+C1W_N)-1 : 8*IMG_N];
  assign c2w_buf  = pay_q[8*(IMG_N+C1W_N+C2W_N)-1 : 8*(IMG_N+C1W_N)];
  assign fc1w_buf = pay_q[8*(FULL_N-FC2W_N)-1 : 8*(IMG_N+C1W_N+C2W_N)];
  assign fc2w_buf = pay_q[8*FULL_N-1 : 8*(FULL_N-FC2W_N)];

  assign s_ready        = s_ready_q;
  assign net_start      = net_start_q;
  assign res_valid      = res_valid_q;
  assign res_data       = res_data_q;
  assign busy           = busy_q;
  assign weights_loaded = wl_q;
`ifdef NPU_LOADER_CHECKSUM_EN
  assign err            = err_q;
`else
  assign err            = 1'b0;
`endif

endmodule
`default_nettype wire
